// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator sequencer: default widths, opcode
// values and FSM state encoding.
package accum_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OPW   = 4;

  localparam logic [DEF_OPW-1:0] OP_NOP  = 4'd0;
  localparam logic [DEF_OPW-1:0] OP_LOAD = 4'd1;
  localparam logic [DEF_OPW-1:0] OP_ADD  = 4'd2;
  localparam logic [DEF_OPW-1:0] OP_SUB  = 4'd3;
  localparam logic [DEF_OPW-1:0] OP_AND  = 4'd4;
  localparam logic [DEF_OPW-1:0] OP_OR   = 4'd5;
  localparam logic [DEF_OPW-1:0] OP_XOR  = 4'd6;
  localparam logic [DEF_OPW-1:0] OP_CLR  = 4'd7;
  localparam logic [DEF_OPW-1:0] OP_MUL  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/accum_reg.sv
// Accumulator storage: a W-bit register with synchronous clear and load enable.
module accum_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/accum_ctrl.sv
// Command sequencer for the accumulator: accepts one ALU command per handshake,
// runs single-cycle ops in EXEC and MUL as a WIDTH-cycle shift-add loop.
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [WIDTH-1:0] acc_q,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               acc_en;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   diff_w;
  logic [2*WIDTH-1:0] prod_step;
  logic               is_mul;
  logic               mul_last;

  assign is_mul   = (op_q == OPW'(OP_MUL));
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  accum_reg #(.W(WIDTH)) u_acc (
    .clk (clk),
    .rst (rst),
    .en  (acc_en),
    .d   (acc_d),
    .q   (acc_q)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic; abort wins over completion in EXEC and MUL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (abort)       state_d = S_IDLE;
        else if (is_mul) state_d = S_MUL;
        else             state_d = S_DONE;
      end
      S_MUL: begin
        if (abort)         state_d = S_IDLE;
        else if (mul_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU with signed overflow detection for ADD/SUB.
  always_comb begin
    sum_w   = acc_q + b_q;
    diff_w  = acc_q - b_q;
    alu_res = acc_q;
    alu_ovf = 1'b0;
    case (op_q)
      OPW'(OP_LOAD): alu_res = b_q;
      OPW'(OP_ADD): begin
        alu_res = sum_w;
        alu_ovf = (acc_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        alu_res = diff_w;
        alu_ovf = (acc_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OPW'(OP_AND): alu_res = acc_q & b_q;
      OPW'(OP_OR):  alu_res = acc_q | b_q;
      OPW'(OP_XOR): alu_res = acc_q ^ b_q;
      OPW'(OP_CLR): alu_res = '0;
      default:      alu_res = acc_q;
    endcase
  end

  // Command latch, shift-add multiplier and accumulator write control.
  always_comb begin
    op_d      = op_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    acc_en    = 1'b0;
    acc_d     = acc_q;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          b_d  = cmd_data;
        end
      end
      S_EXEC: begin
        if (!abort) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = b_q;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            acc_en = 1'b1;
            acc_d  = alu_res;
            ovf_d  = alu_ovf;
          end
        end
      end
      S_MUL: begin
        if (!abort) begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (mul_last) begin
            acc_en = 1'b1;
            acc_d  = prod_step[WIDTH-1:0];
            ovf_d  = |prod_step[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the state alone.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    ovf       = ovf_q;
  end

endmodule
